// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MIPS MEM stage: data memory access with configurable latency and MEM/WB register
module mem_stage_unit #(
    parameter int DEPTH       = 1024,
    parameter int MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_write_reg,
    input  logic [31:0] in_pc_plus4,
    output logic        stall,
    output logic        out_reg_write,
    output logic        out_mem_to_reg,
    output logic [31:0] out_mem_data,
    output logic [31:0] out_alu_res,
    output logic [4:0]  out_write_reg,
    output logic [31:0] out_pc_plus4,
    output logic        out_misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem [DEPTH];

    logic            access;
    logic            misalign;
    logic            aligned;
    logic            advance;
    logic            complete;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [31:0]     rdata;
    logic [31:0]     wmask;
    logic [31:0]     wdata;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_data;

    always_comb begin
        access = in_mem_read | in_mem_write;
        lane   = in_alu_res[1:0];
        idx    = in_alu_res[AW+1:2];
        rdata  = mem[idx];
        case (in_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = access & lane[0];
            default: misalign = access & (|lane);
        endcase
        aligned = access & ~misalign;
        // advance: MEM/WB takes the real instruction this edge rather than a bubble
        if (state == IDLE)
            advance = ~(aligned && (MEM_LATENCY > 1));
        else
            advance = (cnt == CW'(1));
        complete = aligned & advance;
        stall    = ~reset & aligned & ~advance;

        case (in_size)
            2'b00: begin
                wmask = 32'h0000_00FF << {lane, 3'b000};
                wdata = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                wmask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wdata = {2{in_store_data[15:0]}};
            end
            default: begin
                wmask = 32'hFFFF_FFFF;
                wdata = in_store_data;
            end
        endcase

        byte_sel = rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (in_size)
            2'b00:   load_data = {{24{~in_unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~in_unsigned & half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Storage has no reset; the reset gate keeps an aborted store from landing.
    always_ff @(negedge clock) begin
        if (!reset && complete && in_mem_write)
            mem[idx] <= (rdata & ~wmask) | (wdata & wmask);
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            out_reg_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_mem_data   <= '0;
            out_alu_res    <= '0;
            out_write_reg  <= '0;
            out_pc_plus4   <= '0;
            out_misalign   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (!advance) begin
                    state <= WAIT;
                    cnt   <= CW'(MEM_LATENCY - 1);
                end
            end else begin
                if (advance)
                    state <= IDLE;
                else
                    cnt <= cnt - CW'(1);
            end

            if (advance) begin
                out_reg_write  <= in_reg_write & ~misalign;
                out_mem_to_reg <= in_mem_to_reg;
                out_mem_data   <= (in_mem_read && !in_mem_write && !misalign) ? load_data : '0;
                out_alu_res    <= in_alu_res;
                out_write_reg  <= in_write_reg;
                out_pc_plus4   <= in_pc_plus4;
                out_misalign   <= misalign;
            end else begin
                out_reg_write  <= 1'b0;
                out_mem_to_reg <= 1'b0;
                out_mem_data   <= '0;
                out_alu_res    <= '0;
                out_write_reg  <= '0;
                out_pc_plus4   <= '0;
                out_misalign   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - directed self-checking bench for mem_stage_unit at latency 1 and 3
module tb_mem_stage_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_mem_read, in_mem_write, in_reg_write, in_mem_to_reg, in_unsigned;
    logic [1:0]  in_size;
    logic [31:0] in_alu_res, in_store_data, in_pc_plus4;
    logic [4:0]  in_write_reg;

    logic        stall1, reg_write1, mem_to_reg1, misalign1;
    logic [31:0] mem_data1, alu_res1, pc_plus41;
    logic [4:0]  write_reg1;
    logic        stall3, reg_write3, mem_to_reg3, misalign3;
    logic [31:0] mem_data3, alu_res3, pc_plus43;
    logic [4:0]  write_reg3;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clock = ~clock;

    mem_stage_unit #(.DEPTH(1024), .MEM_LATENCY(1)) u1 (
        .clock(clock), .reset(reset),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .in_alu_res(in_alu_res), .in_store_data(in_store_data),
        .in_write_reg(in_write_reg), .in_pc_plus4(in_pc_plus4),
        .stall(stall1), .out_reg_write(reg_write1), .out_mem_to_reg(mem_to_reg1),
        .out_mem_data(mem_data1), .out_alu_res(alu_res1), .out_write_reg(write_reg1),
        .out_pc_plus4(pc_plus41), .out_misalign(misalign1)
    );

    mem_stage_unit #(.DEPTH(1024), .MEM_LATENCY(3)) u3 (
        .clock(clock), .reset(reset),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .in_alu_res(in_alu_res), .in_store_data(in_store_data),
        .in_write_reg(in_write_reg), .in_pc_plus4(in_pc_plus4),
        .stall(stall3), .out_reg_write(reg_write3), .out_mem_to_reg(mem_to_reg3),
        .out_mem_data(mem_data3), .out_alu_res(alu_res3), .out_write_reg(write_reg3),
        .out_pc_plus4(pc_plus43), .out_misalign(misalign3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Drive one instruction at the posedge, half a cycle before the negedge that consumes it.
    task automatic put(input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] wreg, input logic [31:0] pc);
        @(posedge clock);
        in_mem_read = rd;  in_mem_write = wr;  in_reg_write = rw;  in_mem_to_reg = m2r;
        in_size = sz;      in_unsigned = uns;  in_alu_res = addr;  in_store_data = sdata;
        in_write_reg = wreg; in_pc_plus4 = pc;
    endtask

    task automatic tick1(input string tag);
        #1 check({tag, "_stall1"}, {31'd0, stall1}, 32'd0);
        @(negedge clock);
        #1;
    endtask

    // Hold the current instruction on the latency-3 unit until it completes.
    task automatic hold3(input string tag, output int stalls);
        logic s;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            #1 s = stall3;
            @(negedge clock);
            #1;
            if (!s) return;
            stalls++;
            check({tag, "_bubble"}, {31'd0, reg_write3}, 32'd0);
            @(posedge clock);
        end
        check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        put(1, 0, 1, 1, 2'b10, 0, 32'h10, 32'h0, 5'd3, 32'h4);
        #1 check("rst_stall1", {31'd0, stall1}, 32'd0);
        check("rst_stall3", {31'd0, stall3}, 32'd0);
        @(negedge clock); #1;
        check("rst_rw", {31'd0, reg_write1}, 32'd0);
        check("rst_alu", alu_res1, 32'd0);
        check("rst_pc", pc_plus43, 32'd0);
        @(posedge clock);
        reset = 1'b0;

        // Latency 1: word store/load
        put(0, 1, 0, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd0, 32'h100);
        tick1("sw10");
        put(1, 0, 1, 1, 2'b10, 0, 32'h10, 32'h0, 5'd5, 32'h104);
        tick1("lw10");
        check("lw10_data", mem_data1, 32'hDEADBEEF);
        check("lw10_rw", {31'd0, reg_write1}, 32'd1);
        check("lw10_wreg", {27'd0, write_reg1}, 32'd5);
        check("lw10_pc", pc_plus41, 32'h104);

        // Sub-word loads and store
        put(0, 1, 0, 0, 2'b10, 0, 32'h20, 32'h80FF7F01, 5'd0, 32'h108);
        tick1("sw20");
        put(1, 0, 1, 1, 2'b00, 0, 32'h23, 32'h0, 5'd6, 32'h10C);
        tick1("lb23");
        check("lb23", mem_data1, 32'hFFFFFF80);
        put(1, 0, 1, 1, 2'b00, 1, 32'h23, 32'h0, 5'd6, 32'h110);
        tick1("lbu23");
        check("lbu23", mem_data1, 32'h00000080);
        put(1, 0, 1, 1, 2'b01, 0, 32'h22, 32'h0, 5'd6, 32'h114);
        tick1("lh22");
        check("lh22", mem_data1, 32'hFFFF80FF);
        put(0, 1, 0, 0, 2'b00, 0, 32'h21, 32'h123456AA, 5'd0, 32'h118);
        tick1("sb21");
        put(1, 0, 1, 1, 2'b10, 0, 32'h20, 32'h0, 5'd7, 32'h11C);
        tick1("lw20");
        check("lw20_merge", mem_data1, 32'h80FFAA01);

        // Address wrap
        put(0, 1, 0, 0, 2'b10, 0, 32'h1000, 32'h12345678, 5'd0, 32'h120);
        tick1("sw1000");
        put(1, 0, 1, 1, 2'b10, 0, 32'h0, 32'h0, 5'd8, 32'h124);
        tick1("lw0");
        check("wrap_data", mem_data1, 32'h12345678);

        // Non-memory pass-through
        put(0, 0, 1, 0, 2'b10, 0, 32'hA5A5_0003, 32'h0, 5'd9, 32'h128);
        tick1("alu");
        check("alu_res", alu_res1, 32'hA5A5_0003);
        check("alu_rw", {31'd0, reg_write1}, 32'd1);
        check("alu_m2r", {31'd0, mem_to_reg1}, 32'd0);

        // Clear the latency-3 unit before its own tests
        reset = 1'b1;
        @(negedge clock); @(negedge clock);
        @(posedge clock);
        reset = 1'b0;

        // Latency 3: store then held load
        put(0, 1, 0, 0, 2'b10, 0, 32'h50, 32'hCAFEF00D, 5'd0, 32'h200);
        hold3("sw50", n);
        check("sw50_stalls", n, 32'd2);
        put(1, 0, 1, 1, 2'b10, 0, 32'h50, 32'h0, 5'd10, 32'h204);
        hold3("lw50", n);
        check("lw50_stalls", n, 32'd2);
        check("lw50_data", mem_data3, 32'hCAFEF00D);
        check("lw50_rw", {31'd0, reg_write3}, 32'd1);
        put(0, 0, 1, 0, 2'b10, 0, 32'h77, 32'h0, 5'd11, 32'h208);
        #1 check("next_stall3", {31'd0, stall3}, 32'd0);
        @(negedge clock); #1;
        check("next_alu", alu_res3, 32'h77);
        check("next_wreg", {27'd0, write_reg3}, 32'd11);

        // Misaligned accesses complete in one cycle
        put(0, 1, 0, 0, 2'b10, 0, 32'h30, 32'h01234567, 5'd0, 32'h20C);
        hold3("sw30", n);
        put(1, 0, 1, 1, 2'b10, 0, 32'h22, 32'h0, 5'd12, 32'h210);
        #1 check("mis_lw_stall", {31'd0, stall3}, 32'd0);
        @(negedge clock); #1;
        check("mis_lw_flag", {31'd0, misalign3}, 32'd1);
        check("mis_lw_rw", {31'd0, reg_write3}, 32'd0);
        check("mis_lw_data", mem_data3, 32'd0);
        put(0, 1, 0, 0, 2'b01, 0, 32'h31, 32'hFFFF, 5'd0, 32'h214);
        #1 check("mis_sh_stall", {31'd0, stall3}, 32'd0);
        @(negedge clock); #1;
        check("mis_sh_flag", {31'd0, misalign3}, 32'd1);
        put(1, 0, 1, 1, 2'b10, 0, 32'h30, 32'h0, 5'd13, 32'h218);
        hold3("lw30", n);
        check("lw30_data", mem_data3, 32'h01234567);
        check("lw30_mis", {31'd0, misalign3}, 32'd0);

        // Reset aborts a store in flight
        put(0, 1, 0, 0, 2'b10, 0, 32'h40, 32'h11111111, 5'd0, 32'h21C);
        hold3("sw40a", n);
        put(0, 1, 1, 1, 2'b10, 0, 32'h40, 32'h55, 5'd14, 32'h220);
        #1 check("sw40b_stall", {31'd0, stall3}, 32'd1);
        @(negedge clock); #2;
        reset = 1'b1;
        #1 check("abort_stall", {31'd0, stall3}, 32'd0);
        check("abort_rw", {31'd0, reg_write3}, 32'd0);
        check("abort_alu", alu_res3, 32'd0);
        check("abort_pc", pc_plus43, 32'd0);
        @(negedge clock); @(negedge clock);
        put(1, 0, 1, 1, 2'b10, 0, 32'h40, 32'h0, 5'd15, 32'h224);
        reset = 1'b0;
        hold3("lw40", n);
        check("lw40_stalls", n, 32'd2);
        check("lw40_data", mem_data3, 32'h11111111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EXE/MEM pipeline register.
- Consumes the registered ALU result (address), store data, destination register, pc+4 and control bits; performs byte/half/word data-memory access with configurable latency.
- Stalls upstream while an access is in flight; owns the MEM/WB pipeline register that feeds write-back.

Parameters:
- DEPTH, 1024: data memory size in 32-bit words (power of two).
- MEM_LATENCY, 1: cycles per load/store access (>=1).

Ports:
- clock  in  1  pipeline clock; all state updates on negedge, same as the other pipeline registers.
- reset  in  1  asynchronous, active-high reset.
- in_mem_read  in  1  load request.
- in_mem_write  in  1  store request.
- in_reg_write  in  1  instruction writes the register file.
- in_mem_to_reg  in  1  write-back selects memory data.
- in_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- in_unsigned  in  1  zero-extend sub-word loads.
- in_alu_res  in  32  effective address / ALU result.
- in_store_data  in  32  store data (low bits used for sub-word stores).
- in_write_reg  in  5  destination register.
- in_pc_plus4  in  32  pc+4, passed through for jal.
- stall  out  1  combinational; upstream (PC, IF/ID, ID/EXE, EXE/MEM) holds while high.
- out_reg_write  out  1  MEM/WB regWrite.
- out_mem_to_reg  out  1  MEM/WB memToReg.
- out_mem_data  out  32  extended load data.
- out_alu_res  out  32  registered ALU result.
- out_write_reg  out  5  registered destination register.
- out_pc_plus4  out  32  registered pc+4.
- out_misalign  out  1  registered instruction was a misaligned access.

Behaviour:
- Access: access = in_mem_read | in_mem_write. A simultaneous read and write is treated as a write only.
- Addressing:
  - Word index = in_alu_res[log2(DEPTH)+1:2]; upper bits are ignored, so addresses wrap.
  - Little-endian byte lanes. Byte lane = addr[1:0]; half lane = addr[1].
- Misalignment:
  - Condition: half with addr[0]=1, or word with addr[1:0]!=0.
  - Completes in 1 cycle regardless of MEM_LATENCY.
  - No memory write; out_reg_write=0, out_misalign=1, out_mem_data=0.
- Loads: byte/half sign-extended unless in_unsigned; word returned as-is.
- Stores: write only the addressed byte/half lanes; other lanes are preserved.
- FSM states are IDLE and WAIT, with counter cnt.
  - IDLE, no access or misaligned: MEM/WB loads at next negedge; stall=0.
  - IDLE, aligned access, MEM_LATENCY=1: access performed and MEM/WB loaded at the same negedge; stall=0.
  - IDLE, aligned access, MEM_LATENCY>1: stall=1. Negedge -> WAIT with cnt=MEM_LATENCY-1; MEM/WB loads a bubble (all control outputs 0).
  - WAIT, cnt>1: stall=1; cnt decrements; MEM/WB loads a bubble.
  - WAIT, cnt==1: stall=0. At the negedge the memory access is performed, MEM/WB loads the result, and the FSM returns to IDLE. Upstream advances on the same edge.
- Memory timing: write and read are both performed at the completion edge. A load issued directly after a store to the same word returns the new data.
- Non-memory instructions pass alu_res, write_reg, pc_plus4, reg_write and mem_to_reg through unchanged with 1-cycle latency.
- Reset:
  - All outputs 0, state IDLE, cnt 0.
  - Memory array is not reset.
  - Reset during WAIT aborts the access; no memory write occurs.
  - stall=0 while reset is high.

Test Plan:
1. MEM_LATENCY=1: sw 0xDEADBEEF @0x10, then lw @0x10 -> out_mem_data=0xDEADBEEF one cycle later, out_reg_write=1, stall never high.
2. Sub-word: after word 0x80FF7F01 @0x20:
   - lb @0x23 -> 0xFFFFFF80; lbu @0x23 -> 0x00000080; lh @0x22 -> 0xFFFF80FF.
   - sb 0xAA @0x21 then lw @0x20 -> 0x80FFAA01.
3. MEM_LATENCY=3, lw held at inputs -> stall high for exactly 2 cycles, 2 bubbles emitted (out_reg_write=0), result on the 3rd negedge; next instruction accepted on the following edge.
4. Misaligned lw @0x22 and sh @0x31 -> out_misalign=1, out_reg_write=0, stall=0 even with MEM_LATENCY=3; lw @0x30 afterwards shows unchanged contents.
5. Address wrap, DEPTH=1024: sw 0x12345678 @0x1000 then lw @0x0 -> 0x12345678.
6. MEM_LATENCY=3: assert reset during WAIT of sw 0x55 @0x40 -> all outputs 0, stall 0 immediately; after reset, lw @0x40 returns the pre-store value.
